ysyx_22041211_wbu: RTL and testbench
====================================

// Module: ysyx_22041211_wbu
// PURPOSE
//  Writeback unit: sits between EXU/LSU and the register file. Accepts results from two
//  sources over valid/ready, buffers one entry per source, extends/aligns load data, and
//  drives the register-file write port (regWrite/rd/wdata), one write per cycle.
//  Also emits a one-cycle retire pulse with PC for commit tracking.
// PARAMETERS
//  ADDR_WIDTH  16  register count; rd width = $clog2(ADDR_WIDTH)
//  DATA_WIDTH  32  data width; load extension logic is defined for 32 only
// PORTS
//  clk          in   1   clock, all state on posedge
//  rst          in   1   asynchronous reset, active-low (0 = reset)
//  exu_valid    in   1   EXU result valid
//  exu_ready    out  1   EXU slot can accept
//  exu_wen      in   1   EXU result writes a register
//  exu_rd       in   RW  EXU destination (RW = $clog2(ADDR_WIDTH))
//  exu_result   in   DW  EXU result
//  exu_pc       in   32  PC of EXU instruction
//  lsu_valid    in   1   load result valid
//  lsu_ready    out  1   LSU slot can accept
//  lsu_rd       in   RW  load destination
//  lsu_rdata    in   DW  raw 32-bit word from memory
//  lsu_addr_lo  in   2   byte offset addr[1:0]
//  lsu_funct3   in   3   load type (RV32 funct3)
//  lsu_pc       in   32  PC of load instruction
//  regWrite     out  1   register-file write enable
//  rd           out  RW  register-file write address
//  wdata        out  DW  register-file write data
//  retire       out  1   one-cycle pulse per retired instruction
//  retire_pc    out  32  PC of retiring instruction
//  load_err     out  1   pulse with retire: misaligned or illegal funct3 load
// BEHAVIOUR
//  Reset (rst=0, async): both slots EMPTY, age bit=0; regWrite, rd, wdata, retire, retire_pc,
//   load_err all 0; exu_ready/lsu_ready 0 while rst=0. Buffered entries are dropped.
//  Slots: EXU and LSU each EMPTY/FULL. Handshake fires when valid&ready on a posedge;
//   slot becomes FULL with captured fields. x_ready = EMPTY | (FULL & selected this cycle).
//   Inputs must hold stable while valid&!ready; valid never depends on ready.
//  Select: exactly one FULL slot -> it drains. Both FULL -> older drains (age bit set at capture);
//   captured in the same cycle -> LSU drains first. Drained slot goes EMPTY unless refilled same edge.
//  Outputs registered: entry selected in cycle N drives regWrite/rd/wdata/retire in cycle N+1;
//   capture at edge N -> earliest output cycle N+1; register file holds value after edge N+2.
//  Idle cycle: regWrite=0, retire=0, load_err=0; rd/wdata hold last values.
//  regWrite = wen & (rd != 0); EXU wen=0 or rd=0 still retires (retire=1, regWrite=0). LSU wen=1.
//  Load data: sh = lsu_rdata >> (8*addr_lo). 000 LB sext sh[7:0]; 001 LH sext sh[15:0];
//   010 LW lsu_rdata; 100 LBU zext sh[7:0]; 101 LHU zext sh[15:0].
//   LH/LHU with addr_lo=3, LW with addr_lo!=0 -> load_err=1, wdata=extension of shifted bits as above.
//   funct3 011/110/111 -> wdata=0, regWrite=0, load_err=1; still retires.
//  Throughput: sustained 1 retire/cycle; both sources continuously valid -> alternating by age.
//  Reset asserted mid-transfer: outputs drop to 0 immediately; no partial write issued.
// TESTING
//  EXU rd=5 result=0x1234 pc=0x80000000 at N -> cycle N+1 regWrite=1 rd=5 wdata=0x1234 retire=1.
//  LSU rdata=0x80FF7F01 LB addr_lo=2 -> wdata=0xFFFFFFFF; LBU addr_lo=3 -> 0x00000080; LH lo=0 -> 0x00007F01.
//  Both valid same cycle (EXU rd=1, LSU rd=2) -> rd=2 at N+1, rd=1 at N+2; exu_ready=0 at N.
//  EXU captured at N, LSU at N+1 while EXU stalled -> EXU retires first (age rule).
//  EXU rd=0 wen=1 -> retire=1 regWrite=0; LSU LW addr_lo=1 -> load_err=1; funct3=011 -> regWrite=0.
//  rst=0 asserted with both slots FULL -> same cycle all outputs 0; after release no stale retire.

Source files
------------

// File: rtl/ysyx_22041211_wbu.sv
// ---------------------------------------------------------------------------
// ysyx_22041211_wbu -- writeback unit
//
// Collects results from the execute unit (EXU) and the load/store unit (LSU)
// over valid/ready. Each source owns a single-entry slot. Every cycle at most
// one full slot is drained into the registered register-file write port, so
// there is at most one register write and one retire pulse per cycle.
// Load data is shifted by the byte offset and sign/zero extended at drain
// time.
//
// Ports
//   clk                      clock, all state on posedge
//   rst                      asynchronous reset, active low (0 = reset)
//   exu_valid / exu_ready    EXU handshake
//   exu_wen, exu_rd          EXU write enable and destination register
//   exu_result, exu_pc       EXU result and instruction PC
//   lsu_valid / lsu_ready    LSU handshake
//   lsu_rd, lsu_rdata        load destination and raw memory word
//   lsu_addr_lo, lsu_funct3  byte offset and RV32 load type
//   lsu_pc                   load instruction PC
//   regWrite, rd, wdata      register-file write port (registered)
//   retire, retire_pc        one-cycle pulse and PC per retired instruction
//   load_err                 misaligned or illegal-funct3 load, with retire
// ---------------------------------------------------------------------------
module ysyx_22041211_wbu #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  localparam int RW = $clog2(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  // EXU source
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic                  exu_wen,
  input  logic [RW-1:0]         exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_result,
  input  logic [31:0]           exu_pc,
  // LSU source
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [RW-1:0]         lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_rdata,
  input  logic [1:0]            lsu_addr_lo,
  input  logic [2:0]            lsu_funct3,
  input  logic [31:0]           lsu_pc,
  // register-file write port and commit tracking
  output logic                  regWrite,
  output logic [RW-1:0]         rd,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  retire,
  output logic [31:0]           retire_pc,
  output logic                  load_err
);

  // RV32 load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // ---------------------------------------------------------------------
  // Slot state and captured fields
  // ---------------------------------------------------------------------
  logic                  exu_full_reg, exu_full_next;
  logic                  exu_wen_reg;
  logic [RW-1:0]         exu_rd_reg;
  logic [DATA_WIDTH-1:0] exu_result_reg;
  logic [31:0]           exu_pc_reg;

  logic                  lsu_full_reg, lsu_full_next;
  logic [RW-1:0]         lsu_rd_reg;
  logic [DATA_WIDTH-1:0] lsu_rdata_reg;
  logic [1:0]            lsu_lo_reg;
  logic [2:0]            lsu_f3_reg;
  logic [31:0]           lsu_pc_reg;

  // 1 = the EXU entry is older than the LSU entry
  logic                  age_reg, age_next;

  logic                  sel_exu, sel_lsu;
  logic                  exu_fire, lsu_fire;
  logic                  exu_held, lsu_held;

  // next values of the registered outputs
  logic                  reg_write_next;
  logic [RW-1:0]         rd_next;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic                  retire_next;
  logic [31:0]           retire_pc_next;
  logic                  load_err_next;

  // load formatting
  logic [DATA_WIDTH-1:0] load_shifted;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_legal;
  logic                  load_misaligned;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exu_full_reg   <= 1'b0;
      exu_wen_reg    <= 1'b0;
      exu_rd_reg     <= '0;
      exu_result_reg <= '0;
      exu_pc_reg     <= '0;
      lsu_full_reg   <= 1'b0;
      lsu_rd_reg     <= '0;
      lsu_rdata_reg  <= '0;
      lsu_lo_reg     <= '0;
      lsu_f3_reg     <= '0;
      lsu_pc_reg     <= '0;
      age_reg        <= 1'b0;
      regWrite       <= 1'b0;
      rd             <= '0;
      wdata          <= '0;
      retire         <= 1'b0;
      retire_pc      <= '0;
      load_err       <= 1'b0;
    end else begin
      exu_full_reg <= exu_full_next;
      lsu_full_reg <= lsu_full_next;
      age_reg      <= age_next;
      if (exu_fire) begin
        exu_wen_reg    <= exu_wen;
        exu_rd_reg     <= exu_rd;
        exu_result_reg <= exu_result;
        exu_pc_reg     <= exu_pc;
      end
      if (lsu_fire) begin
        lsu_rd_reg    <= lsu_rd;
        lsu_rdata_reg <= lsu_rdata;
        lsu_lo_reg    <= lsu_addr_lo;
        lsu_f3_reg    <= lsu_funct3;
        lsu_pc_reg    <= lsu_pc;
      end
      regWrite  <= reg_write_next;
      rd        <= rd_next;
      wdata     <= wdata_next;
      retire    <= retire_next;
      retire_pc <= retire_pc_next;
      load_err  <= load_err_next;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state: selection, ready, slot occupancy, age
  // ---------------------------------------------------------------------
  always_comb begin
    // With both slots full the older one wins; age_reg=0 also covers the
    // "captured on the same edge" case, which favours the LSU.
    sel_exu = exu_full_reg & (~lsu_full_reg | age_reg);
    sel_lsu = lsu_full_reg & (~exu_full_reg | ~age_reg);

    // A slot can take a new entry when empty or when it is draining now.
    // Ready is forced low while reset is held.
    exu_ready = rst & (~exu_full_reg | sel_exu);
    lsu_ready = rst & (~lsu_full_reg | sel_lsu);

    exu_fire = exu_valid & exu_ready;
    lsu_fire = lsu_valid & lsu_ready;

    exu_held = exu_full_reg & ~sel_exu;
    lsu_held = lsu_full_reg & ~sel_lsu;

    exu_full_next = exu_fire | exu_held;
    lsu_full_next = lsu_fire | lsu_held;

    // One slot always drains when both are full, so at most one slot can
    // carry an entry across the edge. The EXU entry is older after the edge
    // exactly when it is the one that stayed; any other combination either
    // leaves at most one slot occupied or is a same-edge capture pair.
    age_next = exu_held;
  end

  // ---------------------------------------------------------------------
  // Output formation
  // ---------------------------------------------------------------------
  always_comb begin
    load_shifted    = lsu_rdata_reg >> {lsu_lo_reg, 3'b000};
    load_data       = '0;
    load_legal      = 1'b1;
    load_misaligned = 1'b0;
    case (lsu_f3_reg)
      F3_LB:  load_data = {{(DATA_WIDTH-8){load_shifted[7]}}, load_shifted[7:0]};
      F3_LH: begin
        load_data       = {{(DATA_WIDTH-16){load_shifted[15]}}, load_shifted[15:0]};
        load_misaligned = (lsu_lo_reg == 2'd3);
      end
      F3_LW: begin
        // aligned case reduces to the raw word since the shift is zero
        load_data       = load_shifted;
        load_misaligned = (lsu_lo_reg != 2'd0);
      end
      F3_LBU: load_data = {{(DATA_WIDTH-8){1'b0}}, load_shifted[7:0]};
      F3_LHU: begin
        load_data       = {{(DATA_WIDTH-16){1'b0}}, load_shifted[15:0]};
        load_misaligned = (lsu_lo_reg == 2'd3);
      end
      default: load_legal = 1'b0;
    endcase

    // idle cycle: no write, no retire; address/data/pc keep their values
    reg_write_next = 1'b0;
    rd_next        = rd;
    wdata_next     = wdata;
    retire_next    = 1'b0;
    retire_pc_next = retire_pc;
    load_err_next  = 1'b0;

    if (sel_lsu) begin
      reg_write_next = load_legal & (lsu_rd_reg != '0);
      rd_next        = lsu_rd_reg;
      wdata_next     = load_data;
      retire_next    = 1'b1;
      retire_pc_next = lsu_pc_reg;
      load_err_next  = ~load_legal | load_misaligned;
    end else if (sel_exu) begin
      reg_write_next = exu_wen_reg & (exu_rd_reg != '0);
      rd_next        = exu_rd_reg;
      wdata_next     = exu_result_reg;
      retire_next    = 1'b1;
      retire_pc_next = exu_pc_reg;
    end
  end

endmodule

// File: tb/tb_ysyx_22041211_wbu.sv
module tb_ysyx_22041211_wbu;

  logic        clk;
  logic        rst;
  logic        exu_valid, exu_ready, exu_wen;
  logic [3:0]  exu_rd;
  logic [31:0] exu_result, exu_pc;
  logic        lsu_valid, lsu_ready;
  logic [3:0]  lsu_rd;
  logic [31:0] lsu_rdata;
  logic [1:0]  lsu_addr_lo;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_pc;
  logic        regWrite;
  logic [3:0]  rd;
  logic [31:0] wdata;
  logic        retire;
  logic [31:0] retire_pc;
  logic        load_err;

  int n_vec = 0;
  int n_err = 0;

  ysyx_22041211_wbu #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_wen(exu_wen),
    .exu_rd(exu_rd), .exu_result(exu_result), .exu_pc(exu_pc),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd),
    .lsu_rdata(lsu_rdata), .lsu_addr_lo(lsu_addr_lo), .lsu_funct3(lsu_funct3),
    .lsu_pc(lsu_pc),
    .regWrite(regWrite), .rd(rd), .wdata(wdata), .retire(retire),
    .retire_pc(retire_pc), .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference rules for loads ----------------
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] lo,
                                           input logic [2:0] f3);
    logic [31:0] sh;
    sh = w >> (8 * lo);
    case (f3)
      3'd0:    return 32'($signed(sh[7:0]));
      3'd1:    return 32'($signed(sh[15:0]));
      3'd2:    return sh;
      3'd4:    return {24'd0, sh[7:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_legal(input logic [2:0] f3);
    return !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
  endfunction

  function automatic logic ref_err(input logic [1:0] lo, input logic [2:0] f3);
    return !ref_legal(f3) || (f3 == 3'd2 && lo != 2'd0) ||
           ((f3 == 3'd1 || f3 == 3'd5) && lo == 2'd3);
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_exu(input logic v, input logic wen, input logic [3:0] r,
                           input logic [31:0] res, input logic [31:0] pc);
    exu_valid = v; exu_wen = wen; exu_rd = r; exu_result = res; exu_pc = pc;
  endtask

  task automatic drive_lsu(input logic v, input logic [3:0] r, input logic [31:0] data,
                           input logic [1:0] lo, input logic [2:0] f3, input logic [31:0] pc);
    lsu_valid = v; lsu_rd = r; lsu_rdata = data; lsu_addr_lo = lo; lsu_funct3 = f3; lsu_pc = pc;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    drive_exu(0, 0, 0, 0, 0);
    drive_lsu(0, 0, 0, 0, 0, 0);
    tick(); tick();
    n_vec++;
    if ({regWrite, rd, wdata, retire, retire_pc, load_err} !== 71'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h want 0", {regWrite, rd, wdata, retire, retire_pc, load_err});
    end
    n_vec++;
    if ({exu_ready, lsu_ready} !== 2'b00) begin
      n_err++; $display("FAIL reset_ready: got %b want 00", {exu_ready, lsu_ready});
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({exu_ready, lsu_ready} !== 2'b11) begin
      n_err++; $display("FAIL release_ready: got %b want 11", {exu_ready, lsu_ready});
    end
    tick();
  endtask

  task automatic test_exu_basic();
    drive_exu(1, 1, 4'd5, 32'h1234, 32'h8000_0000);
    n_vec++;
    if (exu_ready !== 1'b1) begin
      n_err++; $display("FAIL exu_ready_idle: got %b want 1", exu_ready);
    end
    tick();
    drive_exu(0, 0, 0, 0, 0);
    n_vec++;
    if (retire !== 1'b0) begin
      n_err++; $display("FAIL exu_latency: retire got %b want 0", retire);
    end
    tick();
    n_vec++;
    if ({regWrite, rd, wdata, retire, retire_pc, load_err} !==
        {1'b1, 4'd5, 32'h1234, 1'b1, 32'h8000_0000, 1'b0}) begin
      n_err++;
      $display("FAIL exu_write: got we=%b rd=%0d wdata=%h ret=%b pc=%h err=%b want 1 5 1234 1 80000000 0",
               regWrite, rd, wdata, retire, retire_pc, load_err);
    end
    tick();
    n_vec++;
    if ({regWrite, retire, rd, wdata} !== {1'b0, 1'b0, 4'd5, 32'h1234}) begin
      n_err++;
      $display("FAIL exu_idle_hold: got we=%b ret=%b rd=%0d wdata=%h want 0 0 5 1234",
               regWrite, retire, rd, wdata);
    end
  endtask

  task automatic test_load_ext();
    logic [1:0]  lo_t  [6] = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd1, 2'd0};
    logic [2:0]  f3_t  [6] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd1, 3'd2};
    logic [31:0] exp_t [6] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'h0000_7F01,
                               32'h0000_FF7F, 32'hFFFF_FF7F, 32'h80FF_7F01};
    for (int i = 0; i < 6; i++) begin
      drive_lsu(1, 4'(i + 1), 32'h80FF_7F01, lo_t[i], f3_t[i], 32'h100 + 32'(4 * i));
      tick();
      drive_lsu(0, 0, 0, 0, 0, 0);
      tick();
      n_vec++;
      if ({regWrite, rd, wdata, retire, retire_pc, load_err} !==
          {1'b1, 4'(i + 1), exp_t[i], 1'b1, 32'h100 + 32'(4 * i), 1'b0}) begin
        n_err++;
        $display("FAIL load_ext[%0d]: got we=%b rd=%0d wdata=%h ret=%b pc=%h err=%b want wdata=%h",
                 i, regWrite, rd, wdata, retire, retire_pc, load_err, exp_t[i]);
      end
    end
  endtask

  task automatic test_same_cycle();
    drive_exu(1, 1, 4'd1, 32'h11, 32'h300);
    drive_lsu(1, 4'd2, 32'h22, 2'd0, 3'd2, 32'h304);
    tick();
    drive_exu(0, 0, 0, 0, 0);
    drive_lsu(0, 0, 0, 0, 0, 0);
    n_vec++;
    if ({exu_ready, lsu_ready} !== 2'b01) begin
      n_err++; $display("FAIL same_cycle_ready: got %b want 01", {exu_ready, lsu_ready});
    end
    tick();
    n_vec++;
    if ({regWrite, rd, wdata, retire, retire_pc} !== {1'b1, 4'd2, 32'h22, 1'b1, 32'h304}) begin
      n_err++;
      $display("FAIL same_cycle_first: got rd=%0d wdata=%h ret=%b pc=%h want rd=2 22 1 304",
               rd, wdata, retire, retire_pc);
    end
    tick();
    n_vec++;
    if ({regWrite, rd, wdata, retire, retire_pc} !== {1'b1, 4'd1, 32'h11, 1'b1, 32'h300}) begin
      n_err++;
      $display("FAIL same_cycle_second: got rd=%0d wdata=%h ret=%b pc=%h want rd=1 11 1 300",
               rd, wdata, retire, retire_pc);
    end
    tick();
  endtask

  task automatic test_age();
    drive_exu(1, 1, 4'd1, 32'h11, 32'h400);
    drive_lsu(1, 4'd2, 32'h22, 2'd0, 3'd2, 32'h404);
    tick();
    drive_exu(0, 0, 0, 0, 0);
    drive_lsu(1, 4'd4, 32'h44, 2'd0, 3'd2, 32'h408);
    n_vec++;
    if ({exu_ready, lsu_ready} !== 2'b01) begin
      n_err++; $display("FAIL age_ready_a: got %b want 01", {exu_ready, lsu_ready});
    end
    tick();
    drive_lsu(0, 0, 0, 0, 0, 0);
    n_vec++;
    if ({exu_ready, lsu_ready, rd} !== {2'b10, 4'd2}) begin
      n_err++;
      $display("FAIL age_ready_b: got rdy=%b rd=%0d want rdy=10 rd=2", {exu_ready, lsu_ready}, rd);
    end
    tick();
    n_vec++;
    if ({retire, rd, wdata} !== {1'b1, 4'd1, 32'h11}) begin
      n_err++; $display("FAIL age_older_exu: got ret=%b rd=%0d wdata=%h want 1 1 11", retire, rd, wdata);
    end
    tick();
    n_vec++;
    if ({retire, rd, wdata} !== {1'b1, 4'd4, 32'h44}) begin
      n_err++; $display("FAIL age_newer_lsu: got ret=%b rd=%0d wdata=%h want 1 4 44", retire, rd, wdata);
    end
    tick();
  endtask

  task automatic test_rd0_and_err();
    drive_exu(1, 1, 4'd0, 32'hDEAD, 32'h500);
    tick();
    drive_exu(0, 0, 0, 0, 0);
    tick();
    n_vec++;
    if ({regWrite, retire, load_err, retire_pc} !== {3'b010, 32'h500}) begin
      n_err++;
      $display("FAIL exu_rd0: got we=%b ret=%b err=%b pc=%h want 0 1 0 500",
               regWrite, retire, load_err, retire_pc);
    end
    drive_lsu(1, 4'd9, 32'h1122_3344, 2'd1, 3'd2, 32'h504);
    tick();
    drive_lsu(0, 0, 0, 0, 0, 0);
    tick();
    n_vec++;
    if ({regWrite, rd, wdata, retire, load_err} !== {1'b1, 4'd9, 32'h0011_2233, 2'b11}) begin
      n_err++;
      $display("FAIL lw_misaligned: got we=%b rd=%0d wdata=%h ret=%b err=%b want 1 9 00112233 1 1",
               regWrite, rd, wdata, retire, load_err);
    end
    drive_lsu(1, 4'd10, 32'hFFFF_FFFF, 2'd0, 3'd3, 32'h508);
    tick();
    drive_lsu(0, 0, 0, 0, 0, 0);
    tick();
    n_vec++;
    if ({regWrite, wdata, retire, load_err, retire_pc} !== {1'b0, 32'd0, 2'b11, 32'h508}) begin
      n_err++;
      $display("FAIL illegal_f3: got we=%b wdata=%h ret=%b err=%b pc=%h want 0 0 1 1 508",
               regWrite, wdata, retire, load_err, retire_pc);
    end
  endtask

  task automatic test_reset_mid();
    drive_exu(1, 1, 4'd3, 32'h33, 32'h600);
    drive_lsu(1, 4'd6, 32'hAA, 2'd0, 3'd2, 32'h604);
    tick();
    drive_exu(0, 0, 0, 0, 0);
    drive_lsu(1, 4'd7, 32'hBB, 2'd0, 3'd2, 32'h608);
    tick();
    drive_lsu(0, 0, 0, 0, 0, 0);
    n_vec++;
    if ({retire, rd} !== {1'b1, 4'd6}) begin
      n_err++; $display("FAIL pre_reset_retire: got ret=%b rd=%0d want 1 6", retire, rd);
    end
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({regWrite, rd, wdata, retire, retire_pc, load_err} !== 71'd0) begin
      n_err++;
      $display("FAIL async_reset_outputs: got %h want 0", {regWrite, rd, wdata, retire, retire_pc, load_err});
    end
    n_vec++;
    if ({exu_ready, lsu_ready} !== 2'b00) begin
      n_err++; $display("FAIL async_reset_ready: got %b want 00", {exu_ready, lsu_ready});
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({regWrite, retire} !== 2'b00) begin
        n_err++; $display("FAIL stale_after_reset[%0d]: got we=%b ret=%b want 0 0", i, regWrite, retire);
      end
    end
  endtask

  // Cycle-level model: at most one pending entry per source, tagged with its
  // capture cycle; each cycle the oldest pending entry (LSU on a tie) retires
  // and appears on the outputs after the next edge.
  task automatic test_random(input int n);
    logic        pe_v, pl_v, pe_wen;
    int          pe_ts, pl_ts;
    logic [3:0]  pe_rd, pl_rd;
    logic [31:0] pe_res, pe_pc, pl_data, pl_pc;
    logic [1:0]  pl_lo;
    logic [2:0]  pl_f3;
    logic [70:0] exp_o, obs;
    logic        sel_e, sel_l, er, lr, e_fire, l_fire;
    int          prob;
    pe_v = 0; pl_v = 0; pe_ts = 0; pl_ts = 0;
    pe_wen = 0; pe_rd = 0; pe_res = 0; pe_pc = 0;
    pl_rd = 0; pl_data = 0; pl_pc = 0; pl_lo = 0; pl_f3 = 0;
    e_fire = 1; l_fire = 1;
    drive_exu(0, 0, 0, 0, 0);
    drive_lsu(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_o = '0;
    for (int c = 0; c < n; c++) begin
      obs = {regWrite, rd, wdata, retire, retire_pc, load_err};
      n_vec++;
      if (obs !== exp_o) begin
        n_err++;
        $display("FAIL random_out[%0d]: got we=%b rd=%0d wdata=%h ret=%b pc=%h err=%b want we=%b rd=%0d wdata=%h ret=%b pc=%h err=%b",
                 c, obs[70], obs[69:66], obs[65:34], obs[33], obs[32:1], obs[0],
                 exp_o[70], exp_o[69:66], exp_o[65:34], exp_o[33], exp_o[32:1], exp_o[0]);
      end
      prob = (c < n / 2) ? 50 : 90;
      if (!exu_valid || e_fire)
        drive_exu($urandom_range(0, 99) < prob, 1'($urandom_range(0, 1)), 4'($urandom),
                  $urandom, $urandom);
      if (!lsu_valid || l_fire)
        drive_lsu($urandom_range(0, 99) < prob, 4'($urandom), $urandom,
                  2'($urandom), 3'($urandom_range(0, 7)), $urandom);
      sel_e = pe_v && (!pl_v || pe_ts < pl_ts);
      sel_l = pl_v && !sel_e;
      er = !pe_v || sel_e;
      lr = !pl_v || sel_l;
      #1;
      n_vec++;
      if ({exu_ready, lsu_ready} !== {er, lr}) begin
        n_err++;
        $display("FAIL random_ready[%0d]: got %b want %b", c, {exu_ready, lsu_ready}, {er, lr});
      end
      e_fire = exu_valid && er;
      l_fire = lsu_valid && lr;
      if (sel_e)
        exp_o = {pe_wen && pe_rd != 0, pe_rd, pe_res, 1'b1, pe_pc, 1'b0};
      else if (sel_l)
        exp_o = {ref_legal(pl_f3) && pl_rd != 0, pl_rd, ref_load(pl_data, pl_lo, pl_f3),
                 1'b1, pl_pc, ref_err(pl_lo, pl_f3)};
      else
        exp_o = {1'b0, exp_o[69:34], 1'b0, exp_o[32:1], 1'b0};
      if (sel_e) pe_v = 0;
      if (sel_l) pl_v = 0;
      if (e_fire) begin
        pe_v = 1; pe_ts = c; pe_wen = exu_wen; pe_rd = exu_rd; pe_res = exu_result; pe_pc = exu_pc;
      end
      if (l_fire) begin
        pl_v = 1; pl_ts = c; pl_rd = lsu_rd; pl_data = lsu_rdata; pl_lo = lsu_addr_lo;
        pl_f3 = lsu_funct3; pl_pc = lsu_pc;
      end
      tick();
    end
    drive_exu(0, 0, 0, 0, 0);
    drive_lsu(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0;
    drive_exu(0, 0, 0, 0, 0);
    drive_lsu(0, 0, 0, 0, 0, 0);
    test_reset();
    test_exu_basic();
    test_load_ext();
    test_same_cycle();
    test_age();
    test_rd0_and_err();
    test_reset_mid();
    test_random(600);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
